// File: rtl/reg_bus_master_pkg.sv
// Shared definitions for the control-register bus initiator: FSM state encodings,
// phase-counter width and the phase reload helper.
package reg_bus_master_pkg;

    localparam int PHASE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_e;

    // A phase lasting n cycles is entered with the counter at n-1.
    function automatic logic [PHASE_W-1:0] phase_load(input int cycles);
        phase_load = PHASE_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/reg_bus_phase_counter.sv
// Loadable down-counter with a zero flag; times the SETUP, STROBE and HOLD phases.
module reg_bus_phase_counter
    import reg_bus_master_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [PHASE_W-1:0] load_value,
    output logic               zero
);

    logic [PHASE_W-1:0] count_r;

    // Count down to zero and park there until the next load.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= load_value;
        end else if (count_r != '0) begin
            count_r <= count_r - 1'b1;
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == '0);

endmodule

// File: rtl/reg_bus_master.sv
// Control-register bus initiator: valid/ready commands become timed rd/wr strobes.
// Optional burst support is enabled by defining REG_BUS_BURST_EN.
module reg_bus_master
    import reg_bus_master_pkg::*;
#(
    parameter int ADDR_WIDTH    = 16,
    parameter int DATA_WIDTH    = 16,
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1,
    parameter int LEN_WIDTH     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [1:0]            cmd_be,
    input  logic [DATA_WIDTH-1:0] cmd_data,
`ifdef REG_BUS_BURST_EN
    input  logic [LEN_WIDTH-1:0]  cmd_len,
`endif
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_last,
    output logic                  bus_en,
    output logic                  bus_rd,
    output logic                  bus_wr,
    output logic [1:0]            bus_be,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_data_out,
    input  logic [DATA_WIDTH-1:0] bus_data_in
);

    state_e                state_r, state_nxt;
    logic                  write_r, write_nxt;
    logic [1:0]            be_r, be_nxt;
    logic [ADDR_WIDTH-1:0] addr_r, addr_nxt;
    logic [DATA_WIDTH-1:0] data_r, data_nxt;
    logic [LEN_WIDTH-1:0]  beats_r, beats_nxt;
    logic [LEN_WIDTH-1:0]  cmd_len_s;
    logic                  phase_load_s;
    logic [PHASE_W-1:0]    phase_value_s;
    logic                  phase_zero_s;
    logic                  sample_s;

`ifdef REG_BUS_BURST_EN
    assign cmd_len_s = cmd_len;
`else
    assign cmd_len_s = '0;
`endif

    reg_bus_phase_counter u_phase (
        .clk        (clk),
        .reset      (reset),
        .load       (phase_load_s),
        .load_value (phase_value_s),
        .zero       (phase_zero_s)
    );

    // Next-state logic; beats_r counts the beats remaining after the current one.
    always_comb begin
        state_nxt     = state_r;
        write_nxt     = write_r;
        be_nxt        = be_r;
        addr_nxt      = addr_r;
        data_nxt      = data_r;
        beats_nxt     = beats_r;
        phase_load_s  = 1'b0;
        phase_value_s = '0;
        sample_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    state_nxt     = ST_SETUP;
                    write_nxt     = cmd_write;
                    be_nxt        = cmd_be;
                    addr_nxt      = cmd_addr;
                    data_nxt      = cmd_data;
                    beats_nxt     = cmd_len_s;
                    phase_load_s  = 1'b1;
                    phase_value_s = phase_load(SETUP_CYCLES);
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (phase_zero_s) begin
                    state_nxt     = ST_STROBE;
                    phase_load_s  = 1'b1;
                    phase_value_s = phase_load(STROBE_CYCLES);
                end else begin
                    state_nxt = ST_SETUP;
                end
            end
            ST_STROBE: begin
                if (phase_zero_s) begin
                    state_nxt     = ST_HOLD;
                    phase_load_s  = 1'b1;
                    phase_value_s = phase_load(HOLD_CYCLES);
                    sample_s      = !write_r;
                end else begin
                    state_nxt = ST_STROBE;
                end
            end
            ST_HOLD: begin
                if (phase_zero_s && (beats_r != '0)) begin
                    state_nxt     = ST_SETUP;
                    addr_nxt      = addr_r + 1'b1;
                    beats_nxt     = beats_r - 1'b1;
                    phase_load_s  = 1'b1;
                    phase_value_s = phase_load(SETUP_CYCLES);
                end else if (phase_zero_s) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_HOLD;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, latched command and registered bus/response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            write_r      <= 1'b0;
            be_r         <= 2'b00;
            addr_r       <= '0;
            data_r       <= '0;
            beats_r      <= '0;
            cmd_ready    <= 1'b1;
            bus_en       <= 1'b0;
            bus_rd       <= 1'b0;
            bus_wr       <= 1'b0;
            bus_be       <= 2'b00;
            bus_addr     <= '0;
            bus_data_out <= '0;
            rsp_valid    <= 1'b0;
            rsp_last     <= 1'b0;
            rsp_data     <= '0;
        end else begin
            state_r      <= state_nxt;
            write_r      <= write_nxt;
            be_r         <= be_nxt;
            addr_r       <= addr_nxt;
            data_r       <= data_nxt;
            beats_r      <= beats_nxt;
            cmd_ready    <= (state_nxt == ST_IDLE);
            bus_en       <= (state_nxt != ST_IDLE);
            bus_rd       <= (state_nxt == ST_STROBE) && !write_nxt;
            bus_wr       <= (state_nxt == ST_STROBE) && write_nxt;
            bus_be       <= (state_nxt != ST_IDLE) ? be_nxt : 2'b00;
            bus_addr     <= (state_nxt != ST_IDLE) ? addr_nxt : '0;
            bus_data_out <= ((state_nxt != ST_IDLE) && write_nxt) ? data_nxt : '0;
            rsp_valid    <= sample_s;
            rsp_last     <= sample_s && (beats_r == '0);
            rsp_data     <= sample_s ? bus_data_in : rsp_data;
        end
    end

endmodule

// File: tb/tb_reg_bus_master.sv
// Directed bench for reg_bus_master with a small byte-enabled register file model.
// Define REG_BUS_BURST_EN to also exercise the wrapping burst read.
module tb_reg_bus_master;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [15:0] cmd_addr;
    logic [1:0]  cmd_be;
    logic [15:0] cmd_data;
`ifdef REG_BUS_BURST_EN
    logic [7:0]  cmd_len;
`endif
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_last;
    logic        bus_en;
    logic        bus_rd;
    logic        bus_wr;
    logic [1:0]  bus_be;
    logic [15:0] bus_addr;
    logic [15:0] bus_data_out;
    logic [15:0] bus_data_in;

    int n_vec  = 0;
    int n_fail = 0;

    reg_bus_master dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_be       (cmd_be),
        .cmd_data     (cmd_data),
`ifdef REG_BUS_BURST_EN
        .cmd_len      (cmd_len),
`endif
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_last     (rsp_last),
        .bus_en       (bus_en),
        .bus_rd       (bus_rd),
        .bus_wr       (bus_wr),
        .bus_be       (bus_be),
        .bus_addr     (bus_addr),
        .bus_data_out (bus_data_out),
        .bus_data_in  (bus_data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Target register file: captures on the falling edge of bus_wr.
    logic [15:0] regs [16];
    logic        wr_q;
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) regs[i] <= 16'h0000;
            wr_q <= 1'b0;
        end else begin
            wr_q <= bus_wr;
            if (wr_q && !bus_wr) begin
                regs[bus_addr[3:0]] <= {bus_be[1] ? bus_data_out[15:8] : regs[bus_addr[3:0]][15:8],
                                        bus_be[0] ? bus_data_out[7:0]  : regs[bus_addr[3:0]][7:0]};
            end
        end
    end
    assign bus_data_in = regs[bus_addr[3:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int guard = 0;
        @(negedge clk);
        while (!cmd_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (!cmd_ready) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    // Issue one command and check every bus/response signal cycle by cycle
    // (default timing: SETUP 1, STROBE 2, HOLD 1 per beat).
    task automatic do_cmd(input logic wr, input logic [15:0] addr, input logic [1:0] be,
                          input logic [15:0] data, input int beats,
                          input logic chk_data, input logic [15:0] exp_rsp);
        int pos, beat;
        logic in_cmd, strobe, rsp;
        logic [15:0] exp_addr;
        wait_ready();
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_be = be; cmd_data = data;
`ifdef REG_BUS_BURST_EN
        cmd_len = 8'(beats - 1);
`endif
        @(posedge clk);
        #1 cmd_valid = 1'b0; cmd_addr = 16'h5A5A; cmd_data = 16'hC3C3; cmd_be = 2'b00;
        for (int k = 1; k <= 4 * beats + 1; k++) begin
            @(negedge clk);
            pos      = (k - 1) % 4;
            beat     = (k - 1) / 4;
            in_cmd   = (k <= 4 * beats);
            strobe   = in_cmd && (pos == 1 || pos == 2);
            rsp      = in_cmd && !wr && (pos == 3);
            exp_addr = in_cmd ? addr + 16'(beat) : 16'h0000;
            chk($sformatf("bus_en@%0d", k), bus_en, in_cmd);
            chk($sformatf("bus_wr@%0d", k), bus_wr, strobe && wr);
            chk($sformatf("bus_rd@%0d", k), bus_rd, strobe && !wr);
            chk($sformatf("bus_addr@%0d", k), bus_addr, exp_addr);
            chk($sformatf("bus_be@%0d", k), bus_be, in_cmd ? be : 2'b00);
            chk($sformatf("bus_data_out@%0d", k), bus_data_out, (in_cmd && wr) ? data : 16'h0000);
            chk($sformatf("rsp_valid@%0d", k), rsp_valid, rsp);
            chk($sformatf("rsp_last@%0d", k), rsp_last, rsp && (beat == beats - 1));
            chk($sformatf("cmd_ready@%0d", k), cmd_ready, !in_cmd);
            if (rsp && chk_data) chk($sformatf("rsp_data@%0d", k), rsp_data, exp_rsp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [1:0]  be;
        logic [15:0] data;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [8];
    int   acc [3];
    int   idx, guard;
    logic ready_seen;

    initial begin
        // exp: read data for reads, target register content afterwards for writes.
        vecs[0] = '{1'b1, 16'h0003, 2'b11, 16'hFFFF, 16'hFFFF};
        vecs[1] = '{1'b1, 16'h0002, 2'b11, 16'h1234, 16'h1234};
        vecs[2] = '{1'b1, 16'h0005, 2'b11, 16'hBEEF, 16'hBEEF};
        vecs[3] = '{1'b0, 16'h0002, 2'b11, 16'h0000, 16'h1234};
        vecs[4] = '{1'b1, 16'h0003, 2'b01, 16'hAA55, 16'hFF55};
        vecs[5] = '{1'b0, 16'h0003, 2'b11, 16'h0000, 16'hFF55};
        vecs[6] = '{1'b1, 16'h0007, 2'b10, 16'h1234, 16'h1200};
        vecs[7] = '{1'b0, 16'h0005, 2'b01, 16'h0000, 16'hBEEF};

        reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 16'h0000;
        cmd_be = 2'b00; cmd_data = 16'h0000;
`ifdef REG_BUS_BURST_EN
        cmd_len = 8'd0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_cmd_ready", cmd_ready, 1'b1);
        chk("reset_bus_en", bus_en, 1'b0);
        chk("reset_bus_addr", bus_addr, 16'h0000);
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        reset = 1'b0;

        for (int v = 0; v < 8; v++) begin
            do_cmd(vecs[v].wr, vecs[v].addr, vecs[v].be, vecs[v].data, 1, 1'b1, vecs[v].exp);
            if (vecs[v].wr) chk($sformatf("reg[%0d] after vec %0d", vecs[v].addr, v),
                                regs[vecs[v].addr[3:0]], vecs[v].exp);
        end

        // Back-to-back: cmd_valid held high across three writes.
        wait_ready();
        idx = 0; guard = 0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_be = 2'b11;
        cmd_addr = 16'h0008; cmd_data = 16'h0808;
        while (idx < 3 && guard < 40) begin
            if (guard > 0) @(negedge clk);
            ready_seen = cmd_ready;
            chk($sformatf("b2b_overlap@%0d", guard), cmd_ready && bus_en, 1'b0);
            @(posedge clk);
            if (ready_seen) begin
                acc[idx] = guard;
                idx++;
                #1;
                cmd_addr = 16'h0008 + 16'(idx);
                cmd_data = 16'h0808 + 16'(idx) * 16'h0101;
                if (idx == 3) cmd_valid = 1'b0;
            end
            guard++;
        end
        chk("b2b_accepts", idx, 3);
        chk("b2b_gap_1", acc[1] - acc[0], 5);
        chk("b2b_gap_2", acc[2] - acc[1], 5);
        wait_ready();
        chk("b2b_reg10", regs[10], 16'h0A0A);

`ifdef REG_BUS_BURST_EN
        do_cmd(1'b0, 16'hFFFE, 2'b11, 16'h0000, 3, 1'b0, 16'h0000);
`endif

        // Reset during STROBE of a read aborts it without a response.
        wait_ready();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0002; cmd_be = 2'b11;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_in_strobe", bus_rd, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_bus_en", bus_en, 1'b0);
        chk("abort_bus_rd", bus_rd, 1'b0);
        chk("abort_bus_addr", bus_addr, 16'h0000);
        chk("abort_cmd_ready", cmd_ready, 1'b1);
        chk("abort_rsp_valid", rsp_valid, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("abort_no_rsp@%0d", k), rsp_valid, 1'b0);
            chk($sformatf("abort_idle@%0d", k), bus_en, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
